// File: rtl/game_turn_ctrl_pkg.sv
// Shared encodings and width helpers for the multi-player game-flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TURN  = 2'b01,
        ST_JUDGE = 2'b10,
        ST_END   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        GS_PLAYING = 2'b00,
        GS_WIN     = 2'b01,
        GS_TIE     = 2'b10,
        GS_NO_GAME = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        JR_CONTINUE   = 2'b00,
        JR_WIN        = 2'b01,
        JR_BOARD_FULL = 2'b10,
        JR_FULL_ALIAS = 2'b11
    } judge_e;

    function automatic int player_width(input int num_players);
        int w;
        w = $clog2(num_players);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int count_width(input int max_moves);
        return $clog2(max_moves + 1);
    endfunction

    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Move/verdict handshake between the move decoder (master) and the turn controller (slave).
interface game_turn_ctrl_if #(
    parameter int PW = 1
);
    logic          move_valid;
    logic [PW-1:0] move_player;
    logic          move_ready;
    logic          judge_valid;
    logic [1:0]    judge_result;

    modport master (
        output move_valid,
        output move_player,
        output judge_valid,
        output judge_result,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_player,
        input  judge_valid,
        input  judge_result,
        output move_ready
    );
endinterface

// File: rtl/game_turn_ctrl_timer.sv
// Per-turn cycle counter; expired is high while the count sits on the last allowed cycle.
module turn_timer #(
    parameter int TW      = 4,
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == TW'(TIMEOUT - 1));
endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for N players: accepts moves, waits for the board verdict, tracks
// move count, optional per-turn timeout, and reports winner/tie.
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MAX_MOVES   = 42,
    parameter int TIMEOUT     = 0,
    localparam int PW  = player_width(NUM_PLAYERS),
    localparam int MCW = count_width(MAX_MOVES),
    localparam int TW  = timer_width(TIMEOUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    game_turn_ctrl_if.slave    bus,
    output logic [1:0]         state,
    output logic [PW-1:0]      cur_player,
    output logic [1:0]         game_status,
    output logic [PW-1:0]      winner,
    output logic [MCW-1:0]     move_count,
    output logic               move_accept,
    output logic               move_reject,
    output logic               turn_timeout
);
    state_e         state_reg, state_next;
    status_e        status_reg, status_next;
    logic [PW-1:0]  cur_player_reg, cur_player_next;
    logic [PW-1:0]  winner_reg, winner_next;
    logic [MCW-1:0] move_count_reg, move_count_next;
    logic           accept_reg, accept_next;
    logic           reject_reg, reject_next;
    logic           timeout_reg, timeout_next;

    logic   move_hit;
    logic   timeout_evt;
    logic   cap_reached;
    logic   timer_expired;
    logic   timer_clear;
    judge_e verdict;

    function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
        return (p == PW'(NUM_PLAYERS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign verdict     = judge_e'(bus.judge_result);
    assign move_hit    = (state_reg == ST_TURN) && bus.move_valid &&
                         (bus.move_player == cur_player_reg);
    // An accepted move on the expiry edge beats the timeout.
    assign timeout_evt = (state_reg == ST_TURN) && !abort && !move_hit && timer_expired;
    assign cap_reached = (move_count_reg == MCW'(MAX_MOVES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            status_reg     <= GS_NO_GAME;
            cur_player_reg <= '0;
            winner_reg     <= '0;
            move_count_reg <= '0;
            accept_reg     <= 1'b0;
            reject_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            status_reg     <= status_next;
            cur_player_reg <= cur_player_next;
            winner_reg     <= winner_next;
            move_count_reg <= move_count_next;
            accept_reg     <= accept_next;
            reject_reg     <= reject_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_END: begin
                    if (start) state_next = ST_TURN;
                end
                ST_TURN: begin
                    if (move_hit) state_next = ST_JUDGE;
                end
                ST_JUDGE: begin
                    if (bus.judge_valid) begin
                        state_next = (verdict == JR_CONTINUE && !cap_reached) ? ST_TURN : ST_END;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        status_next     = status_reg;
        cur_player_next = cur_player_reg;
        winner_next     = winner_reg;
        move_count_next = move_count_reg;
        accept_next     = 1'b0;
        reject_next     = 1'b0;
        timeout_next    = 1'b0;
        if (abort) begin
            status_next     = GS_NO_GAME;
            cur_player_next = '0;
            move_count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_END: begin
                    if (start) begin
                        status_next     = GS_PLAYING;
                        cur_player_next = '0;
                        move_count_next = '0;
                    end
                end
                ST_TURN: begin
                    if (move_hit) begin
                        accept_next     = 1'b1;
                        move_count_next = move_count_reg + MCW'(1);
                    end else begin
                        reject_next = bus.move_valid;
                        if (timeout_evt) begin
                            timeout_next    = 1'b1;
                            cur_player_next = next_player(cur_player_reg);
                        end
                    end
                end
                ST_JUDGE: begin
                    if (bus.judge_valid) begin
                        case (verdict)
                            JR_WIN: begin
                                status_next = GS_WIN;
                                winner_next = cur_player_reg;
                            end
                            JR_CONTINUE: begin
                                if (cap_reached) status_next = GS_TIE;
                                else cur_player_next = next_player(cur_player_reg);
                            end
                            default: status_next = GS_TIE;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer only runs across consecutive TURN cycles; any exit, entry or expiry restarts it.
    assign timer_clear = (state_reg != ST_TURN) || (state_next != ST_TURN) || timeout_evt;

    generate
        if (TIMEOUT > 0) begin : g_timer
            turn_timer #(
                .TW      (TW),
                .TIMEOUT (TIMEOUT)
            ) u_timer (
                .clk     (clk),
                .reset   (reset),
                .clear   (timer_clear),
                .enable  (1'b1),
                .expired (timer_expired)
            );
        end else begin : g_no_timer
            logic unused_timer_clear;
            assign unused_timer_clear = timer_clear;
            assign timer_expired      = 1'b0;
        end
    endgenerate

    assign bus.move_ready = (state_reg == ST_TURN);
    assign state          = state_reg;
    assign game_status    = status_reg;
    assign cur_player     = cur_player_reg;
    assign winner         = winner_reg;
    assign move_count     = move_count_reg;
    assign move_accept    = accept_reg;
    assign move_reject    = reject_reg;
    assign turn_timeout   = timeout_reg;
endmodule
